// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO multiply/divide sequencer: one bit per cycle, shift-add multiply,
// restoring divide. Owns HI/LO and stalls the pipeline on HI/LO use while in flight.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_read,
    input  logic             write_hi,
    input  logic             write_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

    state_e               state_q, state_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;          // product / quotient negate
    logic                 rem_neg_q, rem_neg_d;  // remainder follows dividend sign
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     opa_q, opa_d;          // multiplicand / dividend (shifts left)
    logic [WIDTH-1:0]     opb_q, opb_d;          // multiplier (shifts right) / divisor
    logic [2*WIDTH-1:0]   acc_q, acc_d;          // product, or {remainder, quotient}
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH+1:0]     div_trial;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo, rem;

    // NOTE: every variable gets a default at the top of always_comb so that no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        sign_a     = op[0] & a[WIDTH-1];
        sign_b     = op[0] & b[WIDTH-1];

        mul_addend = opb_q[0] ? opa_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

        div_shift  = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
        div_trial  = {1'b0, div_shift} - {2'b0, opb_q};

        prod_fix   = neg_q ? -acc_q : acc_q;
        quo        = acc_q[WIDTH-1:0];
        rem        = acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            S_IDLE: begin
                if (write_hi) hi_d = wdata;
                if (write_lo) lo_d = wdata;
                if (start) begin
                    // Magnitudes of signed operands; -2^(W-1) maps to itself, which is
                    // the correct unsigned magnitude.
                    opa_d      = sign_a ? -a : a;
                    opb_d      = sign_b ? -b : b;
                    acc_d      = '0;
                    cnt_d      = '0;
                    is_div_d   = op[1];
                    neg_d      = sign_a ^ sign_b;
                    rem_neg_d  = sign_a;
                    div_zero_d = (b == '0);
                    busy_d     = 1'b1;
                    state_d    = op[1] ? S_DIV : S_MUL;
                end
            end

            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) state_d = S_FIX;
            end

            S_DIV: begin
                // Non-negative trial keeps the difference; otherwise restore.
                if (!div_trial[WIDTH+1]) begin
                    acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                opa_d = opa_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) state_d = S_FIX;
            end

            S_FIX: begin
                if (is_div_q) begin
                    // Divide by zero leaves |a| as remainder, so sign fixup restores raw a.
                    lo_d = div_zero_q ? '1 : (neg_q ? -quo : quo);
                    hi_d = rem_neg_q ? -rem : rem;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its _d regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = busy_q & (start | hilo_read | write_hi | write_lo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: results, latency, stall and reset.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         hilo_read, write_hi, write_lo;
    logic [W-1:0] wdata;
    logic         busy, done, stall;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .hilo_read (hilo_read),
        .write_hi  (write_hi),
        .write_lo  (write_lo),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents start at a negedge; returns at the first busy-cycle negedge with
    // operands scrambled to show they are not re-sampled.
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
        int n;
        start_op(o, x, y);
        wait_done(n);
        check({tag, " cycles"}, 64'(n), 64'd33);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hilo_read = 1'b0; write_hi = 1'b0; write_lo = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("multu 7*6",     2'b00, 32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A);
        check("done one cycle", 64'(done), 64'd1);
        run_op("mult -3*5",     2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult min*min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div -7/2",      2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu big/2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC);
        run_op("div min/-1",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu x/0",      2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div -8/0",      2'b11, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF);
        @(negedge clk);
        check("done clears", 64'(done), 64'd0);

        // mthi in the same cycle as start lands, then FIX overwrites it.
        wdata    = 32'h5555_5555;
        write_hi = 1'b1;
        start_op(2'b10, 32'd100, 32'd7);
        write_hi = 1'b0;
        check("mthi with start", 64'(hi), 64'h5555_5555);
        wait_done(n);
        check("divu 100/7 hi", 64'(hi), 64'd2);
        check("divu 100/7 lo", 64'(lo), 64'd14);

        // HI/LO use while busy stalls; a second start is dropped.
        start_op(2'b00, 32'd9, 32'd9);
        hilo_read = 1'b1;
        #1 check("stall hilo_read", 64'(stall), 64'd1);
        @(negedge clk);
        hilo_read = 1'b0;
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3;
        #1 check("stall start", 64'(stall), 64'd1);
        @(negedge clk);
        start = 1'b0;
        write_lo = 1'b1; wdata = 32'hDEAD_BEEF;
        #1 check("stall write_lo", 64'(stall), 64'd1);
        @(negedge clk);
        write_lo = 1'b0;
        check("busy hi stable", 64'(hi), 64'd2);
        check("busy lo stable", 64'(lo), 64'd14);
        wait_done(n);
        check("stalled op cycles", 64'(n), 64'd30);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        #1 check("done-cycle stall", 64'(stall), 64'd0);
        check("9*9 lo", 64'(lo), 64'd81);
        check("9*9 hi", 64'(hi), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("done-cycle start accepted", 64'(busy), 64'd1);
        wait_done(n);
        check("reissued cycles", 64'(n), 64'd33);
        check("reissued lo", 64'(lo), 64'd14);
        check("reissued hi", 64'(hi), 64'd2);

        // Reset mid-operation aborts with no result.
        start_op(2'b01, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        repeat (30) @(negedge clk);
        check("abort no late lo", 64'(lo), 64'd0);
        wdata    = 32'h0000_ABCD;
        write_lo = 1'b1;
        @(negedge clk);
        write_lo = 1'b0;
        check("mtlo idle lo", 64'(lo), 64'h0000_ABCD);
        check("mtlo idle hi", 64'(hi), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
